// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Debug read-out engine on a spare register-file read port. On i_start it
//   walks register indices 0..NUM_REGS-1 through the read port and presents
//   each value as one word on a valid/ready stream (index, data, last).
//
// Ports
//   i_clk       clock, rising edge
//   i_arst_n    asynchronous active-low reset
//   i_start     request a dump (sampled only in IDLE)
//   i_abort     cancel a dump in progress
//   o_rd_addr   read-port index to the register file (combinational)
//   i_rd_data   read-port data for o_rd_addr, same cycle
//   o_valid     stream word valid
//   i_ready     downstream accepts word
//   o_index     register index of current word
//   o_data      register value of current word
//   o_last      current word is index NUM_REGS-1
//   o_busy      high whenever the engine is not IDLE
//   o_done      one-cycle pulse after the final word is accepted
//
// state | meaning
// IDLE  | waiting for i_start, read port parked at 0
// SEND  | a word is held on the stream until accepted
// DONE  | final word accepted, o_done pulses for one cycle

module reg_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5
) (
   input  logic              i_clk,
   input  logic              i_arst_n,
   input  logic              i_start,
   input  logic              i_abort,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [ADDR_W-1:0] o_index,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
   localparam logic              FIRST_LAST = (NUM_REGS == 1);

   state_t              state, state_nxt;
   logic                valid_nxt;
   logic                last_nxt;
   logic [ADDR_W-1:0]   index_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic [ADDR_W-1:0]   index_inc;
   logic                handshake;

   assign index_inc = o_index + ADDR_W'(1);
   assign handshake = o_valid & i_ready;
   assign o_busy    = (state != IDLE);
   assign o_done    = (state == DONE);

   // The read port looks one word ahead while sending, so the next value is
   // already on i_rd_data at the edge the current word is accepted.
   always_comb begin
      o_rd_addr = '0;
      if (state == SEND)
         o_rd_addr = o_last ? o_index : index_inc;
   end

   always_comb begin
      state_nxt = state;
      valid_nxt = o_valid;
      last_nxt  = o_last;
      index_nxt = o_index;
      data_nxt  = o_data;
      case (state)
         IDLE: begin
            if (i_start && !i_abort) begin
               data_nxt  = i_rd_data;
               index_nxt = '0;
               last_nxt  = FIRST_LAST;
               valid_nxt = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            // abort wins over a handshake in the same cycle
            if (i_abort) begin
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               index_nxt = '0;
               state_nxt = IDLE;
            end else if (handshake) begin
               if (o_last) begin
                  valid_nxt = 1'b0;
                  last_nxt  = 1'b0;
                  state_nxt = DONE;
               end else begin
                  data_nxt  = i_rd_data;
                  index_nxt = index_inc;
                  last_nxt  = (index_inc == LAST_IDX);
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            index_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state   <= IDLE;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         o_index <= '0;
         o_data  <= '0;
      end else begin
         state   <= state_nxt;
         o_valid <= valid_nxt;
         o_last  <= last_nxt;
         o_index <= index_nxt;
         o_data  <= data_nxt;
      end
   end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

   logic        clk;
   logic        rst_n;
   logic        start, abort, ready;
   logic [4:0]  rd_addr, index;
   logic [31:0] rd_data, data;
   logic        valid, last, busy, done;

   logic        start4, ready4;
   logic [4:0]  rd_addr4, index4;
   logic [31:0] rd_data4, data4;
   logic        valid4, last4, busy4, done4;

   logic [31:0] regs [32];
   logic [4:0]  max_addr4;

   int n_checks = 0;
   int n_pass   = 0;

   assign rd_data  = regs[rd_addr];
   assign rd_data4 = regs[rd_addr4];

   reg_dump_reader #(.NUM_REGS(32), .DATA_W(32), .ADDR_W(5)) u_dut (
      .i_clk(clk), .i_arst_n(rst_n), .i_start(start), .i_abort(abort),
      .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_valid(valid), .i_ready(ready),
      .o_index(index), .o_data(data), .o_last(last), .o_busy(busy), .o_done(done)
   );

   reg_dump_reader #(.NUM_REGS(4), .DATA_W(32), .ADDR_W(5)) u_dut4 (
      .i_clk(clk), .i_arst_n(rst_n), .i_start(start4), .i_abort(1'b0),
      .o_rd_addr(rd_addr4), .i_rd_data(rd_data4), .o_valid(valid4), .i_ready(ready4),
      .o_index(index4), .o_data(data4), .o_last(last4), .o_busy(busy4), .o_done(done4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk)
      if (rd_addr4 > max_addr4) max_addr4 = rd_addr4;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_regs(input logic [31:0] base);
      for (int j = 0; j < 32; j++) regs[j] = base + 32'(j);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; abort = 0; ready = 0; start4 = 0; ready4 = 1;
      max_addr4 = '0;
      fill_regs(32'h1000_0000);
      #12;
      n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
      n_checks++; if (index !== 5'd0) $display("FAIL reset_index got %0d want 0", index); else n_pass++;
      n_checks++; if (data !== 32'd0) $display("FAIL reset_data got %h want 0", data); else n_pass++;
      n_checks++; if (last !== 1'b0) $display("FAIL reset_last got %b want 0", last); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr got %0d want 0", rd_addr); else n_pass++;
      rst_n = 1'b1;
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_full_dump();
      fill_regs(32'h1000_0000);
      ready = 1; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 32; i++) begin
         n_checks++; if (valid !== 1'b1) $display("FAIL full_valid[%0d] got %b want 1", i, valid); else n_pass++;
         n_checks++; if (index !== 5'(i)) $display("FAIL full_index[%0d] got %0d want %0d", i, index, i); else n_pass++;
         n_checks++; if (data !== 32'h1000_0000 + 32'(i)) $display("FAIL full_data[%0d] got %h want %h", i, data, 32'h1000_0000 + 32'(i)); else n_pass++;
         n_checks++; if (last !== (i == 31)) $display("FAIL full_last[%0d] got %b want %b", i, last, (i == 31)); else n_pass++;
         n_checks++; if (busy !== 1'b1) $display("FAIL full_busy[%0d] got %b want 1", i, busy); else n_pass++;
         n_checks++; if (rd_addr !== 5'((i == 31) ? 31 : i + 1)) $display("FAIL full_rd_addr[%0d] got %0d want %0d", i, rd_addr, (i == 31) ? 31 : i + 1); else n_pass++;
         step();
      end
      n_checks++; if (done !== 1'b1) $display("FAIL full_done got %b want 1", done); else n_pass++;
      n_checks++; if (valid !== 1'b0) $display("FAIL full_done_valid got %b want 0", valid); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL full_done_busy got %b want 1", busy); else n_pass++;
      n_checks++; if (last !== 1'b0) $display("FAIL full_done_last got %b want 0", last); else n_pass++;
      n_checks++; if (rd_addr !== 5'd0) $display("FAIL full_done_rd_addr got %0d want 0", rd_addr); else n_pass++;
      step();
      n_checks++; if (done !== 1'b0) $display("FAIL full_after_done got %b want 0", done); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL full_after_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_backpressure();
      int          exp_idx;
      logic [31:0] exp_data;
      logic        fin;
      fill_regs(32'h2000_0000);
      ready = 0; start = 1;
      exp_idx = 0; exp_data = regs[0]; fin = 0;
      step();
      start = 0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         n_checks++; if (valid !== 1'b1) $display("FAIL bp_valid[c%0d] got %b want 1", cyc, valid); else n_pass++;
         n_checks++; if (index !== exp_idx[4:0]) $display("FAIL bp_index[c%0d] got %0d want %0d", cyc, index, exp_idx); else n_pass++;
         n_checks++; if (data !== exp_data) $display("FAIL bp_data[c%0d] got %h want %h", cyc, data, exp_data); else n_pass++;
         n_checks++; if (last !== (exp_idx == 31)) $display("FAIL bp_last[c%0d] got %b want %b", cyc, last, (exp_idx == 31)); else n_pass++;
         ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         if (!ready) begin
            for (int j = 0; j < 32; j++) regs[j] = 32'h3000_0000 + 32'(cyc << 8) + 32'(j);
         end else if (exp_idx == 31) begin
            fin = 1;
         end else begin
            exp_idx++;
            exp_data = regs[exp_idx];
         end
         step();
      end
      n_checks++; if (fin !== 1'b1) $display("FAIL bp_timeout got %b want 1", fin); else n_pass++;
      n_checks++; if (done !== 1'b1) $display("FAIL bp_done got %b want 1", done); else n_pass++;
      ready = 1;
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL bp_idle got %b want 0", busy); else n_pass++;
   endtask

   task automatic drain(input string name);
      logic seen;
      seen = 0;
      ready = 1;
      for (int c = 0; c < 100 && !seen; c++) begin
         if (done === 1'b1) seen = 1;
         step();
      end
      n_checks++; if (seen !== 1'b1) $display("FAIL %s_drain_done got %b want 1", name, seen); else n_pass++;
   endtask

   task automatic test_abort();
      fill_regs(32'h1000_0000);
      ready = 1; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (index !== 5'(i)) $display("FAIL abort_walk_index[%0d] got %0d want %0d", i, index, i); else n_pass++;
         if (i < 7) step();
      end
      abort = 1;
      step();
      abort = 0;
      n_checks++; if (valid !== 1'b0) $display("FAIL abort_valid got %b want 0", valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (index !== 5'd0) $display("FAIL abort_index got %0d want 0", index); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (done !== 1'b0 || valid !== 1'b0) $display("FAIL abort_quiet[%0d] got done=%b valid=%b want 0 0", k, done, valid); else n_pass++;
         step();
      end
      start = 1;
      step();
      start = 0;
      n_checks++; if (valid !== 1'b1) $display("FAIL abort_restart_valid got %b want 1", valid); else n_pass++;
      n_checks++; if (index !== 5'd0) $display("FAIL abort_restart_index got %0d want 0", index); else n_pass++;
      n_checks++; if (data !== 32'h1000_0000) $display("FAIL abort_restart_data got %h want 10000000", data); else n_pass++;
      drain("abort");
   endtask

   task automatic test_start_while_busy();
      int   words, exp;
      logic seen;
      words = 0; exp = 0; seen = 0;
      fill_regs(32'h1000_0000);
      ready = 1; start = 1;
      step();
      start = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         if (done === 1'b1) begin
            seen = 1;
         end else begin
            if (valid === 1'b1) begin
               n_checks++; if (index !== exp[4:0]) $display("FAIL busy_index[w%0d] got %0d want %0d", words, index, exp); else n_pass++;
               exp++; words++;
            end
            start = (valid === 1'b1) && (index == 5'd3);
            step();
         end
      end
      start = 1;
      step();
      start = 0;
      n_checks++; if (busy !== 1'b0) $display("FAIL busy_after_done got %b want 0", busy); else n_pass++;
      step();
      n_checks++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL busy_no_requeue got valid=%b busy=%b want 0 0", valid, busy); else n_pass++;
      n_checks++; if (words !== 32) $display("FAIL busy_word_count got %0d want 32", words); else n_pass++;
      n_checks++; if (seen !== 1'b1) $display("FAIL busy_done_seen got %b want 1", seen); else n_pass++;
   endtask

   task automatic test_async_reset();
      int   words;
      logic seen;
      fill_regs(32'h1000_0000);
      ready = 1; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 12; i++) step();
      n_checks++; if (index !== 5'd12) $display("FAIL arst_pre_index got %0d want 12", index); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (valid !== 1'b0) $display("FAIL arst_valid got %b want 0", valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL arst_done got %b want 0", done); else n_pass++;
      n_checks++; if (index !== 5'd0) $display("FAIL arst_index got %0d want 0", index); else n_pass++;
      n_checks++; if (last !== 1'b0 || data !== 32'd0) $display("FAIL arst_last_data got last=%b data=%h want 0 0", last, data); else n_pass++;
      #2 rst_n = 1'b1;
      step();
      n_checks++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL arst_release got valid=%b busy=%b want 0 0", valid, busy); else n_pass++;
      start = 1;
      step();
      start = 0;
      words = 0; seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         if (done === 1'b1) begin
            seen = 1;
         end else begin
            if (valid === 1'b1) begin
               n_checks++; if (index !== 5'(words) || data !== regs[words]) $display("FAIL arst_clean[w%0d] got idx=%0d data=%h want %0d %h", words, index, data, words, regs[words]); else n_pass++;
               words++;
            end
            step();
         end
      end
      n_checks++; if (words !== 32) $display("FAIL arst_word_count got %0d want 32", words); else n_pass++;
      step();
   endtask

   task automatic test_small();
      fill_regs(32'h4000_0000);
      ready4 = 1; start4 = 1;
      step();
      start4 = 0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (valid4 !== 1'b1) $display("FAIL small_valid[%0d] got %b want 1", i, valid4); else n_pass++;
         n_checks++; if (index4 !== 5'(i)) $display("FAIL small_index[%0d] got %0d want %0d", i, index4, i); else n_pass++;
         n_checks++; if (data4 !== 32'h4000_0000 + 32'(i)) $display("FAIL small_data[%0d] got %h want %h", i, data4, 32'h4000_0000 + 32'(i)); else n_pass++;
         n_checks++; if (last4 !== (i == 3)) $display("FAIL small_last[%0d] got %b want %b", i, last4, (i == 3)); else n_pass++;
         n_checks++; if (busy4 !== 1'b1) $display("FAIL small_busy[%0d] got %b want 1", i, busy4); else n_pass++;
         step();
      end
      n_checks++; if (done4 !== 1'b1 || valid4 !== 1'b0) $display("FAIL small_done got done=%b valid=%b want 1 0", done4, valid4); else n_pass++;
      step();
      n_checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) $display("FAIL small_idle got busy=%b done=%b want 0 0", busy4, done4); else n_pass++;
      n_checks++; if (max_addr4 > 5'd3) $display("FAIL small_rd_addr_max got %0d want <=3", max_addr4); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_dump();
      test_backpressure();
      test_abort();
      test_start_while_busy();
      test_async_reset();
      test_small();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
